aes256_enc_iter: RTL

Iterative AES-256 encryption core, FIPS-197: 128-bit plaintext, 256-bit key, 128-bit ciphertext. It is the forward-direction counterpart of the AES decrypt path in the signature authenticator. It executes one full round per clock and expands the key schedule on the fly, so no round-key RAM is needed. It shares the start/done handshake style of the existing AES wrapper, so the top level can steer encrypt jobs to it.

---
 rtl/aes256_enc_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/aes256_enc_iter.sv
// Iterative AES-256 encryptor: one full round per clock, key schedule expanded on the fly.
// Optional build macro AES_DBG_ROUND_EN adds dbg_state/dbg_round observation ports.
module aes256_enc_iter #(
  parameter int KEY_BW = 256,
  parameter int TXT_BW = 128,
  parameter int NR     = 14
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              enable,
  input  logic [KEY_BW-1:0] key,
  input  logic [TXT_BW-1:0] word,
  output logic [TXT_BW-1:0] result,
  output logic              done,
  output logic              busy
`ifdef AES_DBG_ROUND_EN
  ,
  output logic [TXT_BW-1:0] dbg_state,
  output logic [3:0]        dbg_round
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic {IDLE, RUN} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 (square-and-multiply), then the FIPS affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [255:0] kreg_q;
  logic [3:0]   rnd_q;
  logic [127:0] result_q;
  logic         done_q;
  logic         busy_q;

  logic [127:0] sb, sr, mc, round_d;
  logic [31:0]  w_last, sw_in, sw_out, w0, w1, w2, w3;
  logic [3:0]   rnd_p1;
  logic [7:0]   rcon;
  logic [127:0] next128;

  // Round datapath: state bytes are column-major, byte 0 in the top 8 bits.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(state_q[8*i +: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    round_d = ((rnd_q == LAST_RND) ? sr : mc) ^ kreg_q[127:0];
  end

  // kreg_q holds the last eight schedule words; odd rounds produce an even-indexed
  // round key, which is the half that needs RotWord and Rcon.
  always_comb begin
    w_last = kreg_q[31:0];
    sw_in  = rnd_q[0] ? {w_last[23:0], w_last[31:24]} : w_last;
    sw_out = '0;
    for (int i = 0; i < 4; i++) sw_out[8*i +: 8] = sbox(sw_in[8*i +: 8]);
    rnd_p1  = rnd_q + 4'd1;
    rcon    = 8'h01 << (rnd_p1[3:1] - 3'd1);
    w0      = kreg_q[255:224] ^ sw_out ^ (rnd_q[0] ? {rcon, 24'h000000} : 32'h0);
    w1      = kreg_q[223:192] ^ w0;
    w2      = kreg_q[191:160] ^ w1;
    w3      = kreg_q[159:128] ^ w2;
    next128 = {w0, w1, w2, w3};
  end

  // Handshake: enable is sampled only in IDLE; done pulses for one cycle with result
  // valid, and result holds until the next job finishes or reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      kreg_q   <= '0;
      rnd_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (enable) begin
            state_q <= word ^ key[255:128];
            kreg_q  <= key;
            rnd_q   <= 4'd1;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= round_d;
          kreg_q  <= {kreg_q[127:0], next128};
          if (rnd_q == LAST_RND) begin
            result_q <= round_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            rnd_q    <= 4'd0;
            fsm_q    <= IDLE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

`ifdef AES_DBG_ROUND_EN
  assign dbg_state = state_q;
  assign dbg_round = rnd_q;
`endif

endmodule
